tem_trigger_gen: RTL and testbench

- Upstream stage of the K1/K2 relay-pulse block. Produces the clean, single-clock-domain TEM strobe that the K1 stage edge-detects.
- Two trigger sources:
  - internal burst mode: a programmable number of TEM pulses at a programmable period;
  - external mode: an asynchronous trigger pin, synchronised and debounced, with one TEM pulse per qualified rising edge.
- Guarantees at least one low cycle between TEM pulses, so every pulse is a detectable rising edge downstream.

---
 rtl/tem_trigger_gen_pkg.sv | 17 +
 rtl/tem_sync_debounce.sv | 40 ++++
 rtl/tem_trigger_gen.sv | 135 +++++++++++++
 tb/tb_tem_trigger_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tem_trigger_gen_pkg.sv
// rtl/tem_trigger_gen_pkg.sv - shared types and constants for the TEM trigger generator
package tem_trigger_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_ARMED = 2'd3
    } tem_state_t;

    // TEM high time; the K1 stage sizes its edge detector against this value.
    localparam int HIGH_CYCLES_DEFAULT = 1000;

    localparam logic MODE_INT = 1'b0;
    localparam logic MODE_EXT = 1'b1;

endpackage

// File: rtl/tem_sync_debounce.sv
// rtl/tem_sync_debounce.sv - async input synchroniser, high-level debounce and one-shot qualified edge
module tem_sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic qual
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   sync_hi;

    assign sync_hi = sync_q[SYNC_STAGES-1];

    // The counter parks at TARGET while the input stays high, so only the
    // transition into TARGET produces an event; a low sample re-arms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt    <= '0;
            qual   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            if (!sync_hi) begin
                cnt <= '0;
            end else if (cnt != TARGET) begin
                cnt <= cnt + ONE;
            end
            qual <= sync_hi && (cnt == TARGET - ONE);
        end
    end

endmodule

// File: rtl/tem_trigger_gen.sv
// rtl/tem_trigger_gen.sv - TEM strobe generator: internal bursts or debounced external triggers
module tem_trigger_gen
    import tem_trigger_gen_pkg::*;
#(
    parameter int HIGH_CYCLES = HIGH_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode_ext,
    input  logic             start,
    input  logic [31:0]      period,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             ext_trig,
    output logic             TEM,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             ext_miss
);

    localparam logic [31:0]      MIN_PERIOD = 32'(HIGH_CYCLES + 1);
    localparam logic [31:0]      HIGH_LAST  = 32'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    tem_state_t       state;
    tem_state_t       next_state;
    logic             mode_q;
    logic [31:0]      eff_period_q;
    logic [CNT_W-1:0] burst_q;
    logic [31:0]      timer;
    logic             qual_edge;
    logic             complete;
    logic             launch;
    logic             enter_high;

    tem_sync_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE   (DEBOUNCE)
    ) u_sync_debounce (
        .clk (clk),
        .rst (rst),
        .din (ext_trig),
        .qual(qual_edge)
    );

    assign launch     = (state == ST_IDLE) && start && enable;
    assign enter_high = (next_state == ST_HIGH) && (state != ST_HIGH);

    always_comb begin
        next_state = state;
        complete   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && enable) begin
                    next_state = (mode_ext == MODE_EXT) ? ST_ARMED : ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (timer == HIGH_LAST) begin
                    next_state = ST_LOW;
                end
            end
            ST_LOW: begin
                if (mode_q == MODE_EXT) begin
                    next_state = ST_ARMED;
                end else if (timer == eff_period_q - 32'd1) begin
                    if ((burst_q == '0) || (pulse_cnt < burst_q)) begin
                        next_state = ST_HIGH;
                    end else begin
                        next_state = ST_IDLE;
                        complete   = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (qual_edge) begin
                    next_state = ST_HIGH;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        // Abort takes priority over everything, including burst completion.
        if ((state != ST_IDLE) && !enable) begin
            next_state = ST_IDLE;
            complete   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            TEM          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ext_miss     <= 1'b0;
            pulse_cnt    <= '0;
            mode_q       <= MODE_INT;
            eff_period_q <= MIN_PERIOD;
            burst_q      <= '0;
            timer        <= '0;
        end else begin
            state    <= next_state;
            TEM      <= (next_state == ST_HIGH);
            busy     <= (next_state != ST_IDLE);
            done     <= complete;
            ext_miss <= qual_edge && (mode_q == MODE_EXT) &&
                        ((state == ST_HIGH) || (state == ST_LOW));

            if (launch) begin
                mode_q       <= mode_ext;
                eff_period_q <= (period < MIN_PERIOD) ? MIN_PERIOD : period;
                burst_q      <= burst_len;
            end

            // An internal launch enters HIGH on the same edge, so it counts as pulse one.
            if (launch) begin
                pulse_cnt <= (next_state == ST_HIGH) ? CNT_ONE : '0;
            end else if (enter_high && (pulse_cnt != '1)) begin
                pulse_cnt <= pulse_cnt + CNT_ONE;
            end

            // Timer measures cycles since the current rising edge of TEM.
            if (enter_high) begin
                timer <= '0;
            end else if ((state == ST_HIGH) || (state == ST_LOW)) begin
                timer <= timer + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_tem_trigger_gen.sv
// tb/tb_tem_trigger_gen.sv - self-checking bench for tem_trigger_gen against a pulse-schedule model
module tb_tem_trigger_gen;

    localparam int HC = 1000;
    localparam int SS = 2;
    localparam int DB = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          mode_ext;
    logic          start;
    logic [31:0]   period;
    logic [CW-1:0] burst_len;
    logic          ext_trig;
    logic          TEM;
    logic          busy;
    logic          done;
    logic [CW-1:0] pulse_cnt;
    logic          ext_miss;

    int unsigned cyc = 0;
    int unsigned rise_q[$];
    int unsigned fall_q[$];
    int unsigned done_q[$];
    int unsigned miss_q[$];
    logic        tem_prev = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    tem_trigger_gen #(
        .HIGH_CYCLES(HC),
        .SYNC_STAGES(SS),
        .DEBOUNCE   (DB),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .mode_ext (mode_ext),
        .start    (start),
        .period   (period),
        .burst_len(burst_len),
        .ext_trig (ext_trig),
        .TEM      (TEM),
        .busy     (busy),
        .done     (done),
        .pulse_cnt(pulse_cnt),
        .ext_miss (ext_miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (TEM && !tem_prev) rise_q.push_back(cyc);
        if (!TEM && tem_prev) fall_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (ext_miss) miss_q.push_back(cyc);
        tem_prev <= TEM;
    end

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned eff_of(input int unsigned p);
        return (p < HC + 1) ? HC + 1 : p;
    endfunction

    function automatic int unsigned q_at(input int unsigned q[$], input int k);
        return (k < q.size()) ? q[k] : 0;
    endfunction

    task automatic clear_q();
        rise_q.delete();
        fall_q.delete();
        done_q.delete();
        miss_q.delete();
    endtask

    task automatic do_start(output int unsigned s);
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Internal burst: rising edges at s+1+k*eff, each HC wide, done at s+1+n*eff.
    task automatic run_burst(input int unsigned p, input int unsigned n);
        int unsigned s;
        int unsigned e;
        e = eff_of(p);
        mode_ext  = 1'b0;
        period    = p;
        burst_len = CW'(n);
        clear_q();
        do_start(s);
        for (int i = 0; i < int'(n * e) + 50 && busy; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("burst_busy_end", busy, 0);
        check("burst_rise_cnt", rise_q.size(), n);
        for (int k = 0; k < int'(n); k++) begin
            check("burst_rise_at", q_at(rise_q, k), s + 1 + k * e);
            check("burst_fall_at", q_at(fall_q, k), s + 1 + k * e + HC);
        end
        check("burst_done_cnt", done_q.size(), 1);
        check("burst_done_at", q_at(done_q, 0), s + 1 + n * e);
        check("burst_pulse_cnt", pulse_cnt, n);
    endtask

    // External edge of L high cycles; qualifies only if L reaches DB.
    task automatic ext_pulse(input int L);
        int unsigned c;
        int unsigned exp_rise;
        clear_q();
        @(negedge clk);
        ext_trig = 1'b1;
        c = cyc;
        repeat (L) @(negedge clk);
        ext_trig = 1'b0;
        repeat (HC + 100) @(negedge clk);
        exp_rise = c + SS + DB + 1;
        check($sformatf("ext_rise_cnt_L%0d", L), rise_q.size(), (L >= DB) ? 1 : 0);
        if (L >= DB) begin
            check($sformatf("ext_latency_L%0d", L),
                  (q_at(rise_q, 0) + 1 >= exp_rise) && (q_at(rise_q, 0) <= exp_rise + 1), 1);
            check("ext_width", q_at(fall_q, 0) - q_at(rise_q, 0), HC);
        end
        check("ext_miss_none", miss_q.size(), 0);
        check("ext_still_armed", busy, 1);
    endtask

    initial begin
        int unsigned s;
        int unsigned p;
        int unsigned n;

        rst = 1'b1; enable = 1'b0; mode_ext = 1'b0; start = 1'b0;
        period = 32'd0; burst_len = '0; ext_trig = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tem", TEM, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_miss", ext_miss, 0);
        check("rst_pulse_cnt", pulse_cnt, 0);
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        run_burst(5000, 3);
        run_burst(10, 2);
        for (int i = 0; i < 3; i++) begin
            p = $urandom_range(1, 2000);
            n = $urandom_range(1, 3);
            run_burst(p, n);
        end

        mode_ext = 1'b1;
        do_start(s);
        repeat (4) @(negedge clk);
        check("ext_armed_busy", busy, 1);
        check("ext_armed_tem", TEM, 0);
        ext_pulse(10);
        ext_pulse(40);
        ext_pulse(DB - 1);
        ext_pulse(DB);
        for (int i = 0; i < 3; i++) ext_pulse(int'($urandom_range(4, 30)));

        clear_q();
        @(negedge clk);
        ext_trig = 1'b1;
        repeat (40) @(negedge clk);
        ext_trig = 1'b0;
        repeat (20) @(negedge clk);
        ext_trig = 1'b1;
        repeat (40) @(negedge clk);
        ext_trig = 1'b0;
        repeat (HC + 100) @(negedge clk);
        check("miss_rise_cnt", rise_q.size(), 1);
        check("miss_pulse_cnt", miss_q.size(), 1);
        check("miss_rearmed", busy, 1);
        check("miss_no_done", done_q.size(), 0);

        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        check("ext_abort_busy", busy, 0);

        mode_ext = 1'b0; period = 3000; burst_len = '0;
        clear_q();
        do_start(s);
        repeat (3000 + 300) @(negedge clk);
        check("abort_pre_tem", TEM, 1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_tem", TEM, 0);
        check("abort_busy", busy, 0);
        check("abort_pulse_cnt", pulse_cnt, 2);
        repeat (100) @(negedge clk);
        enable = 1'b1;
        check("abort_no_done", done_q.size(), 0);
        check("abort_rise_cnt", rise_q.size(), 2);
        check("abort_rise2_at", q_at(rise_q, 1), s + 1 + 3000);
        check("abort_cnt_held", pulse_cnt, 2);

        period = 2000; burst_len = CW'(2);
        do_start(s);
        repeat (499) @(negedge clk);
        check("rst_mid_pre_tem", TEM, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_tem", TEM, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pulse_cnt", pulse_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_burst(1500, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
